// File: rtl/dbus_arbiter.sv
// dbus_arbiter: registered data-bus arbiter, fixed-priority or round-robin, with hold-limited lock
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   req[NSRC]          per-source bus request
//   lock[NSRC]         per-source lock request, honoured only for the current owner
//   src_data           packed source data, source i at [i*WIDTH +: WIDTH]
//   grant[NSRC]        registered one-hot grant, zero when idle
//   owner              registered index of granted source, 0 when idle
//   dbus_valid         registered, high while a source is granted
//   dbus_out[WIDTH]    registered data of the granted source, 0 when idle
module dbus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NSRC     = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          req,
  input  logic [NSRC-1:0]          lock,
  input  logic [NSRC*WIDTH-1:0]    src_data,
  output logic [NSRC-1:0]          grant,
  output logic [$clog2(NSRC)-1:0]  owner,
  output logic                     dbus_valid,
  output logic [WIDTH-1:0]         dbus_out
);
  localparam int IW = $clog2(NSRC);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 2;
  logic [IW-1:0] rr_ptr, win, sel, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [NSRC-1:0] own_bit, masked, cand;
  logic held, keep, any;
  int idx;
  always_comb begin
    own_bit = NSRC'(1) << owner;
    held = dbus_valid && req[owner] && lock[owner];
    keep = held && (MAX_HOLD == 0 || hold_cnt < HW'(MAX_HOLD));
    masked = req & ~own_bit;
    // on timeout the owner is masked out, but wins again if nobody else is asking
    cand = !(held && !keep) ? req : (masked != '0) ? masked : own_bit;
    any = |cand;
    win = '0;
    idx = 0;
    // scanning downward leaves the first hit at the lowest offset from the start point
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = (RR_MODE != 0) ? (int'(rr_ptr) + k) % NSRC : k;
      if (cand[idx]) win = IW'(idx);
    end
    sel = keep ? owner : win;
    ptr_n = (win == IW'(NSRC - 1)) ? '0 : win + 1'b1;
    hold_n = keep ? ((&hold_cnt) ? hold_cnt : hold_cnt + 1'b1) : HW'(any);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      owner <= '0;
      dbus_valid <= 1'b0;
      dbus_out <= '0;
      rr_ptr <= '0;
      hold_cnt <= '0;
    end else begin
      grant <= any ? NSRC'(1) << sel : '0;
      owner <= any ? sel : '0;
      dbus_valid <= any;
      dbus_out <= any ? src_data[int'(sel) * WIDTH +: WIDTH] : '0;
      hold_cnt <= hold_n;
      if (!keep && any) rr_ptr <= ptr_n;
    end
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed checks of dbus_arbiter in round-robin and fixed-priority builds
module tb_dbus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic [63:0] src_data = {16'h3333, 16'h2222, 16'h1111, 16'h0111};
  logic [3:0] rr_grant, fp_grant;
  logic [1:0] rr_owner, fp_owner;
  logic rr_valid, fp_valid;
  logic [15:0] rr_out, fp_out;
  int tests = 0;
  int fails = 0;
  dbus_arbiter #(.WIDTH(16), .NSRC(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .src_data(src_data),
    .grant(rr_grant), .owner(rr_owner), .dbus_valid(rr_valid), .dbus_out(rr_out)
  );
  dbus_arbiter #(.WIDTH(16), .NSRC(4), .RR_MODE(0), .MAX_HOLD(4)) u_fp (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .src_data(src_data),
    .grant(fp_grant), .owner(fp_owner), .dbus_valid(fp_valid), .dbus_out(fp_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1'b1;
    req = 4'hF;
    #1;
    chk("rst_rr_grant", 32'(rr_grant), 32'h0);
    chk("rst_rr_out", 32'(rr_out), 32'h0);
    chk("rst_rr_valid", 32'(rr_valid), 32'h0);
    chk("rst_fp_grant", 32'(fp_grant), 32'h0);
    #2 rst = 1'b0;
    step();
    chk("t1_rr_grant", 32'(rr_grant), 32'h1);
    chk("t1_rr_out", 32'(rr_out), 32'h0111);
    chk("t1_rr_valid", 32'(rr_valid), 32'h1);
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_fp_grant", 32'(fp_grant), 32'h2);
      chk("t2_fp_owner", 32'(fp_owner), 32'h1);
      chk("t2_fp_out", 32'(fp_out), 32'h1111);
    end
    req = 4'b1000;
    step();
    chk("t2_fp_grant_b", 32'(fp_grant), 32'h8);
    chk("t2_fp_out_b", 32'(fp_out), 32'h3333);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'hF;
    lock = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_rr_rotate", 32'(rr_grant), 32'(4'b0001 << (i % 4)));
      chk("t3_fp_fixed", 32'(fp_grant), 32'h1);
    end
    req = 4'b0100;
    lock = 4'b0100;
    step();
    chk("t4_rr_grant_first", 32'(rr_grant), 32'h4);
    req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_rr_grant_held", 32'(rr_grant), 32'h4);
      chk("t4_rr_out_held", 32'(rr_out), 32'h2222);
    end
    step();
    chk("t4_rr_timeout", 32'(rr_grant), 32'h8);
    chk("t4_rr_timeout_out", 32'(rr_out), 32'h3333);
    chk("t4_fp_timeout", 32'(fp_grant), 32'h1);
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_rr_regrant", 32'(rr_grant), 32'h4);
      chk("t4_fp_regrant", 32'(fp_grant), 32'h4);
    end
    req = 4'b0010;
    lock = 4'b0010;
    step();
    chk("t5_rr_grant", 32'(rr_grant), 32'h2);
    req = 4'b0000;
    step();
    chk("t5_rr_grant_rel", 32'(rr_grant), 32'h0);
    chk("t5_rr_out_rel", 32'(rr_out), 32'h0);
    chk("t5_rr_valid_rel", 32'(rr_valid), 32'h0);
    chk("t5_rr_owner_rel", 32'(rr_owner), 32'h0);
    req = 4'b0010;
    step();
    chk("t6_rr_grant_pre", 32'(rr_grant), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rr_grant_rst", 32'(rr_grant), 32'h0);
    chk("t6_rr_owner_rst", 32'(rr_owner), 32'h0);
    chk("t6_rr_valid_rst", 32'(rr_valid), 32'h0);
    chk("t6_rr_out_rst", 32'(rr_out), 32'h0);
    chk("t6_fp_valid_rst", 32'(fp_valid), 32'h0);
    #1 rst = 1'b0;
    req = 4'b1001;
    lock = 4'h0;
    step();
    chk("t6_rr_ptr0", 32'(rr_grant), 32'h1);
    chk("t6_rr_out", 32'(rr_out), 32'h0111);
    chk("t6_fp_grant", 32'(fp_grant), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
